alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Round-robin arbiter/sequencer that time-shares one combinational ALU between two requesters.
- Accepts op/operand requests on valid/ready handshakes, drives the shared ALU's A/B/ALU_cont/Cin inputs, waits a fixed settle time, then captures X/Cout/Zero/Overflow.
- Returns the captured result on a single tagged response channel.
- Sits between issue logic and the ALU instance. The ALU stays external; this block only drives and samples its pins.

Parameters:
- WIDTH, 4, operand/result width; matches the ALU A/B/X width.
- ALU_LAT, 1, clock cycles the ALU inputs are held before outputs are sampled; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- r0_valid  in  1  requester 0 has an op
- r0_ready  out  1  requester 0 op accepted this cycle
- r0_op  in  4  ALU control code, requester 0
- r0_a  in  WIDTH  operand A, requester 0
- r0_b  in  WIDTH  operand B, requester 0
- r1_valid / r1_ready / r1_op / r1_a / r1_b  same as r0_*, for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes the response
- rsp_id  out  1  requester that owns the response
- rsp_x  out  WIDTH  captured ALU result
- rsp_cout  out  1  captured carry out
- rsp_zero  out  1  captured zero flag
- rsp_ov  out  1  captured overflow flag
- alu_a  out  WIDTH  drives ALU A
- alu_b  out  WIDTH  drives ALU B
- alu_cont  out  4  drives ALU ALU_cont
- alu_cin  out  1  drives ALU Cin
- alu_x  in  WIDTH  from ALU X
- alu_cout  in  1  from ALU Cout
- alu_zero  in  1  from ALU Zero
- alu_ov  in  1  from ALU Overflow

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - All outputs 0: r*_ready, rsp_*, alu_a, alu_b, alu_cont, alu_cin.
  - Settle counter 0; round-robin pointer last=1, so requester 0 wins first.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = r0 if only r0_valid; r1 if only r1_valid.
  - If both are valid, grant goes to the requester that is not `last`.
  - r*_ready is combinational: ready = (state==IDLE) & valid & granted. At most one ready is high per cycle.
  - On accept edge: register the granted op/a/b into alu_cont/alu_a/alu_b; set alu_cin = op[3] | op[2]; record id; last <= id; counter <= ALU_LAT-1; state -> EXEC.
- EXEC:
  - ALU inputs are held stable.
  - While counter != 0: decrement.
  - When counter == 0: on that edge, capture alu_x/cout/zero/ov into rsp_*; rsp_valid <= 1; state -> RESP.
- RESP:
  - rsp_* is held while rsp_valid & !rsp_ready.
  - On rsp_valid & rsp_ready edge: rsp_valid <= 0; state -> IDLE.
  - No accept happens in the same cycle; both r*_ready are low in EXEC and RESP.
- Latency and throughput:
  - Accept edge T gives rsp_valid high after edge T+ALU_LAT.
  - Minimum initiation interval is ALU_LAT+2 cycles.
- ALU driving in IDLE/RESP: alu_a/alu_b/alu_cont/alu_cin keep the last issued values, so there is no spurious toggling.
- Requesters must hold op/a/b stable while valid and not ready. Dropping valid before ready cancels the request with no side effect.
- Widths: no arithmetic on data; all data fields pass through at WIDTH and 4 bits unchanged.
- Boundary cases:
  - Both requesters continuously valid: grants alternate strictly 0,1,0,1.
  - rsp_ready held low indefinitely: the block stalls in RESP and accepts nothing.
  - Reset asserted in EXEC or RESP: the pending result is discarded, and rsp_valid falls immediately (asynchronous).
  - Op 4'b0000 with zero operands is a legal request.

Optional Feature:
- Macro ALU_SHARE_STATS_EN.
- When defined:
  - Adds outputs gnt_cnt0 and gnt_cnt1, each 8 bits.
  - Each counter increments on its requester's accept edge and saturates at 255.
  - Both clear on reset.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-EXEC -> rsp_valid=0 and alu_cont=0 immediately. After release, with both requesters valid, r0_ready goes high first.
- Single op: r0 op=4'b0010, a=4'b0011, b=4'b0100, ALU_LAT=1.
  - alu_cont=0010 and alu_cin=0 on the cycle after accept.
  - rsp_valid one cycle later, with rsp_id=0 and rsp_x equal to the ALU X sampled (0111 for the team ALU), cout=0, ov=0, zero=0.
- Cin derivation: r1 op=4'b0110 -> alu_cin=1. op=4'b1011 -> alu_cin=1. op=4'b0011 -> alu_cin=0.
- Fairness: r0 and r1 valid continuously for 6 ops with rsp_ready=1 -> rsp_id sequence is 0,1,0,1,0,1, and consecutive accepts are exactly ALU_LAT+2 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_x/flags stable, r0_ready/r1_ready low throughout. rsp_ready=1 -> IDLE next cycle, next accept the cycle after.
- Stats (ALU_SHARE_STATS_EN): 300 r0-only ops -> gnt_cnt0=255, gnt_cnt1=0.

Source files
------------

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sequencer that time-shares one external
// combinational ALU between two requesters.
// Each accepted request drives the ALU pins, waits ALU_LAT cycles, samples
// the ALU outputs, and returns them on one tagged response channel.
// Optional build macro ALU_SHARE_STATS_EN adds per-requester saturating
// 8-bit grant counters (gnt_cnt0 / gnt_cnt1).
module alu_share_arb #(
   parameter int WIDTH   = 4,
   parameter int ALU_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             r0_valid,
   output logic             r0_ready,
   input  logic [3:0]       r0_op,
   input  logic [WIDTH-1:0] r0_a,
   input  logic [WIDTH-1:0] r0_b,
   input  logic             r1_valid,
   output logic             r1_ready,
   input  logic [3:0]       r1_op,
   input  logic [WIDTH-1:0] r1_a,
   input  logic [WIDTH-1:0] r1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_x,
   output logic             rsp_cout,
   output logic             rsp_zero,
   output logic             rsp_ov,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_cont,
   output logic             alu_cin,
   input  logic [WIDTH-1:0] alu_x,
   input  logic             alu_cout,
   input  logic             alu_zero,
   input  logic             alu_ov
`ifdef ALU_SHARE_STATS_EN
   ,
   output logic [7:0]       gnt_cnt0,
   output logic [7:0]       gnt_cnt1
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

   state_t           state;
   state_t           state_nxt;
   logic             last;
   logic             gnt_id;
   logic             accept;
   logic             cur_id;
   logic [3:0]       cnt;
   logic [3:0]       sel_op;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;

   // Round-robin grant: a lone requester wins, a tie goes to the one not served last
   always_comb begin
      gnt_id = 1'b0;
      if (r0_valid && r1_valid) begin
         gnt_id = ~last;
      end else if (r1_valid) begin
         gnt_id = 1'b1;
      end
      sel_op = gnt_id ? r1_op : r0_op;
      sel_a  = gnt_id ? r1_a  : r0_a;
      sel_b  = gnt_id ? r1_b  : r0_b;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept)                 state_nxt = EXEC;
         EXEC: if (cnt == 4'd0)            state_nxt = RESP;
         RESP: if (rsp_valid && rsp_ready) state_nxt = IDLE;
         default:                          state_nxt = IDLE;
      endcase
   end

   // Handshake outputs; ready is forced low while reset is asserted
   always_comb begin
      accept   = rst_n && (state == IDLE) && (r0_valid || r1_valid);
      r0_ready = accept && !gnt_id;
      r1_ready = accept && gnt_id;
   end

   // Datapath: issue to the ALU, count settle cycles, capture and hold the response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_cont  <= '0;
         alu_cin   <= 1'b0;
         cur_id    <= 1'b0;
         last      <= 1'b1;
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_x     <= '0;
         rsp_cout  <= 1'b0;
         rsp_zero  <= 1'b0;
         rsp_ov    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  alu_a    <= sel_a;
                  alu_b    <= sel_b;
                  alu_cont <= sel_op;
                  alu_cin  <= sel_op[3] | sel_op[2];
                  cur_id   <= gnt_id;
                  last     <= gnt_id;
                  cnt      <= LAT_M1;
               end
            end
            EXEC: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  rsp_x     <= alu_x;
                  rsp_cout  <= alu_cout;
                  rsp_zero  <= alu_zero;
                  rsp_ov    <= alu_ov;
                  rsp_id    <= cur_id;
                  rsp_valid <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_valid && rsp_ready) begin
                  rsp_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_SHARE_STATS_EN
   // Saturating grant counters, one per requester
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_cnt0 <= '0;
         gnt_cnt1 <= '0;
      end else begin
         if (r0_ready && gnt_cnt0 != 8'hFF) gnt_cnt0 <= gnt_cnt0 + 8'd1;
         if (r1_ready && gnt_cnt1 != 8'hFF) gnt_cnt1 <= gnt_cnt1 + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed testbench for alu_share_arb with a small behavioural ALU attached.
// Define ALU_SHARE_STATS_EN to also exercise the grant counters.
module tb_alu_share_arb;
   localparam int W   = 4;
   localparam int LAT = 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         r0_valid = 1'b0, r1_valid = 1'b0;
   logic         r0_ready, r1_ready;
   logic [3:0]   r0_op = '0, r1_op = '0;
   logic [W-1:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
   logic         rsp_valid, rsp_ready = 1'b0, rsp_id;
   logic [W-1:0] rsp_x;
   logic         rsp_cout, rsp_zero, rsp_ov;
   logic [W-1:0] alu_a, alu_b, alu_x;
   logic [3:0]   alu_cont;
   logic         alu_cin, alu_cout, alu_zero, alu_ov;
`ifdef ALU_SHARE_STATS_EN
   logic [7:0]   gnt_cnt0, gnt_cnt1;
`endif

   int checks = 0;
   int errors = 0;

   alu_share_arb #(.WIDTH(W), .ALU_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_x(rsp_x),
      .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_ov(rsp_ov),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cont(alu_cont), .alu_cin(alu_cin),
      .alu_x(alu_x), .alu_cout(alu_cout), .alu_zero(alu_zero), .alu_ov(alu_ov)
`ifdef ALU_SHARE_STATS_EN
      , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural ALU: 00 and, 01 or, 10 add (bit2 inverts B), 11 xor
   logic [W-1:0] bmod;
   logic [W:0]   sum;
   always_comb begin
      bmod     = alu_cont[2] ? ~alu_b : alu_b;
      sum      = {1'b0, alu_a} + {1'b0, bmod} + {{W{1'b0}}, alu_cin};
      alu_x    = '0;
      alu_cout = 1'b0;
      alu_ov   = 1'b0;
      case (alu_cont[1:0])
         2'b00: alu_x = alu_a & alu_b;
         2'b01: alu_x = alu_a | alu_b;
         2'b10: begin
            alu_x    = sum[W-1:0];
            alu_cout = sum[W];
            alu_ov   = (alu_a[W-1] == bmod[W-1]) && (sum[W-1] != alu_a[W-1]);
         end
         default: alu_x = alu_a ^ alu_b;
      endcase
      alu_zero = (alu_x == '0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rsp_ready = 1'b0;
      r0_valid = 1'b1; r0_op = 4'b0101; r0_a = 4'h9; r0_b = 4'h6;
      r1_valid = 1'b1; r1_op = 4'b0001; r1_a = 4'h3; r1_b = 4'h4;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      checks++; if (alu_cont !== 4'h0) begin errors++; $display("FAIL reset_alu_cont got %h exp 0", alu_cont); end
      checks++; if (alu_a !== 4'h0) begin errors++; $display("FAIL reset_alu_a got %h exp 0", alu_a); end
      checks++; if (alu_cin !== 1'b0) begin errors++; $display("FAIL reset_alu_cin got %b exp 0", alu_cin); end
      checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b exp 00", r0_ready, r1_ready); end
      rst_n = 1'b1;
      #1;
      checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin errors++; $display("FAIL first_grant got r0=%b r1=%b exp r0=1 r1=0", r0_ready, r1_ready); end
      tick();
      checks++; if (alu_cont !== 4'b0101 || alu_cin !== 1'b1) begin errors++; $display("FAIL exec_issue got cont=%b cin=%b exp 0101/1", alu_cont, alu_cin); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (alu_cont !== 4'h0 || alu_a !== 4'h0) begin errors++; $display("FAIL exec_reset_alu got cont=%h a=%h exp 0/0", alu_cont, alu_a); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL exec_reset_rsp got %b exp 0", rsp_valid); end
      rst_n = 1'b1;
      #1;
      checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin errors++; $display("FAIL regrant_after_reset got r0=%b r1=%b exp r0=1 r1=0", r0_ready, r1_ready); end
      tick();
      tick();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL resp_before_reset got %b exp 1", rsp_valid); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL resp_reset_async got %b exp 0", rsp_valid); end
      r0_valid = 1'b0; r1_valid = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic run_op(input logic id, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic ecin, input logic [3:0] ex, input logic ec, input logic ez, input logic ev);
      logic got;
      rsp_ready = 1'b1;
      if (id) begin r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b; end
      else    begin r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b; end
      #1;
      got = id ? r1_ready : r0_ready;
      checks++; if (got !== 1'b1 || (r0_ready & r1_ready) !== 1'b0) begin errors++; $display("FAIL op%b_ready got r0=%b r1=%b exp only r%0d", op, r0_ready, r1_ready, id); end
      tick();
      r0_valid = 1'b0; r1_valid = 1'b0;
      checks++; if (alu_cont !== op || alu_a !== a || alu_b !== b) begin errors++; $display("FAIL op%b_issue got cont=%b a=%h b=%h exp %b %h %h", op, alu_cont, alu_a, alu_b, op, a, b); end
      checks++; if (alu_cin !== ecin) begin errors++; $display("FAIL op%b_cin got %b exp %b", op, alu_cin, ecin); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL op%b_early_rsp got %b exp 0", op, rsp_valid); end
      repeat (LAT - 1) tick();
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== id) begin errors++; $display("FAIL op%b_rsp got valid=%b id=%b exp 1/%b", op, rsp_valid, rsp_id, id); end
      checks++; if (rsp_x !== ex || rsp_cout !== ec || rsp_zero !== ez || rsp_ov !== ev) begin
         errors++; $display("FAIL op%b_result got x=%b c=%b z=%b v=%b exp x=%b c=%b z=%b v=%b", op, rsp_x, rsp_cout, rsp_zero, rsp_ov, ex, ec, ez, ev); end
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL op%b_rsp_drop got %b exp 0", op, rsp_valid); end
   endtask

   task automatic test_single_op();
      run_op(1'b0, 4'b0010, 4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_cin_and_ops();
      run_op(1'b1, 4'b0110, 4'h5, 4'h5, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
      run_op(1'b0, 4'b1011, 4'h6, 4'h3, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
      run_op(1'b1, 4'b0011, 4'h9, 4'h9, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      run_op(1'b0, 4'b0000, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      run_op(1'b0, 4'b0010, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1);
      run_op(1'b1, 4'b0010, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
      run_op(1'b1, 4'b1010, 4'h2, 4'h3, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_fairness();
      int acc_t[$];
      int n_rsp;
      logic [3:0] ex;
      n_rsp = 0;
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      rsp_ready = 1'b1;
      r0_valid = 1'b1; r0_op = 4'b0010; r0_a = 4'h1; r0_b = 4'h2;
      r1_valid = 1'b1; r1_op = 4'b0001; r1_a = 4'h4; r1_b = 4'h8;
      #1;
      for (int c = 0; c < 60 && n_rsp < 6; c++) begin
         if (r0_ready || r1_ready) acc_t.push_back(c);
         if (rsp_valid) begin
            ex = (n_rsp % 2 == 0) ? 4'h3 : 4'hC;
            checks++; if (rsp_id !== 1'((n_rsp % 2))) begin errors++; $display("FAIL fair_id[%0d] got %b exp %0d", n_rsp, rsp_id, n_rsp % 2); end
            checks++; if (rsp_x !== ex) begin errors++; $display("FAIL fair_x[%0d] got %h exp %h", n_rsp, rsp_x, ex); end
            n_rsp++;
         end
         tick();
      end
      r0_valid = 1'b0; r1_valid = 1'b0;
      checks++; if (n_rsp != 6 || acc_t.size() < 6) begin errors++; $display("FAIL fair_count got rsp=%0d acc=%0d exp 6/6", n_rsp, acc_t.size()); end
      for (int i = 1; i < 6 && i < acc_t.size(); i++) begin
         checks++; if (acc_t[i] - acc_t[i-1] != LAT + 2) begin errors++; $display("FAIL fair_ii[%0d] got %0d exp %0d", i, acc_t[i] - acc_t[i-1], LAT + 2); end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      rsp_ready = 1'b0;
      r0_valid = 1'b1; r0_op = 4'b0001; r0_a = 4'h5; r0_b = 4'hA;
      #1;
      tick();
      r0_valid = 1'b0;
      tick();
      r0_valid = 1'b1; r1_valid = 1'b1; r1_op = 4'b0110; r1_a = 4'h3; r1_b = 4'h1;
      #1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_x !== 4'hF || rsp_cout !== 1'b0 || rsp_zero !== 1'b0 || rsp_ov !== 1'b0) begin
            errors++; $display("FAIL stall_hold[%0d] got v=%b id=%b x=%h c=%b z=%b o=%b exp 1 0 f 0 0 0", i, rsp_valid, rsp_id, rsp_x, rsp_cout, rsp_zero, rsp_ov); end
         checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %b%b exp 00", i, r0_ready, r1_ready); end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL release_rsp got %b exp 0", rsp_valid); end
      checks++; if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin errors++; $display("FAIL release_grant got r0=%b r1=%b exp r0=0 r1=1", r0_ready, r1_ready); end
      tick();
      r0_valid = 1'b0; r1_valid = 1'b0;
      checks++; if (alu_cont !== 4'b0110 || alu_cin !== 1'b1 || alu_a !== 4'h3) begin errors++; $display("FAIL next_issue got cont=%b cin=%b a=%h exp 0110 1 3", alu_cont, alu_cin, alu_a); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_x !== 4'h2 || rsp_cout !== 1'b1) begin
         errors++; $display("FAIL next_rsp got v=%b id=%b x=%h c=%b exp 1 1 2 1", rsp_valid, rsp_id, rsp_x, rsp_cout); end
      tick();
   endtask

`ifdef ALU_SHARE_STATS_EN
   task automatic test_stats();
      int acc;
      acc = 0;
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      checks++; if (gnt_cnt0 !== 8'd0 || gnt_cnt1 !== 8'd0) begin errors++; $display("FAIL stats_reset got %0d/%0d exp 0/0", gnt_cnt0, gnt_cnt1); end
      rsp_ready = 1'b1;
      r0_valid = 1'b1; r0_op = 4'b0001; r0_a = 4'h1; r0_b = 4'h2;
      #1;
      for (int c = 0; c < 2000 && acc < 300; c++) begin
         if (r0_ready) acc++;
         if (acc == 300) r0_valid = 1'b0;
         tick();
      end
      r0_valid = 1'b0;
      repeat (4) tick();
      checks++; if (acc != 300) begin errors++; $display("FAIL stats_accepts got %0d exp 300", acc); end
      checks++; if (gnt_cnt0 !== 8'd255 || gnt_cnt1 !== 8'd0) begin errors++; $display("FAIL stats_sat got %0d/%0d exp 255/0", gnt_cnt0, gnt_cnt1); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_op();
      test_cin_and_ops();
      test_fairness();
      test_back_to_back();
`ifdef ALU_SHARE_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
